// File: rtl/mod_n_updown_counter_pkg.sv
// Shared constants for the modulo-N up/down counter family: default geometry,
// wrap/saturate mode selectors and direction encoding.
package mod_n_updown_counter_pkg;

  localparam int DEF_DIGITS  = 2;
  localparam int DEF_MODULUS = 10;
  localparam int DEF_DIGIT_W = 4;

  localparam int WRAP_MODE = 1;
  localparam int SAT_MODE  = 0;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/mod_n_updown_counter_digit.sv
// One modulo-N digit: clear > load (clamped to MODULUS-1) > step, on the falling edge.
// Exposes at_max/at_zero so the parent can build a ripple-free carry/borrow chain.
module mod_n_updown_counter_digit
  import mod_n_updown_counter_pkg::*;
#(
  parameter int MODULUS = DEF_MODULUS,
  parameter int DIGIT_W = DEF_DIGIT_W
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_digit,
  input  logic               step,
  input  logic               up,
  output logic [DIGIT_W-1:0] value,
  output logic               at_max,
  output logic               at_zero
);

  localparam logic [DIGIT_W-1:0] MAX_VAL = DIGIT_W'(MODULUS - 1);
  localparam logic [DIGIT_W-1:0] ONE     = DIGIT_W'(1);

  logic [DIGIT_W-1:0] load_clamped;
  logic [DIGIT_W-1:0] next_up;
  logic [DIGIT_W-1:0] next_down;

  assign at_max  = (value == MAX_VAL);
  assign at_zero = (value == '0);

  always_comb begin
    load_clamped = (load_digit > MAX_VAL) ? MAX_VAL : load_digit;
    next_up      = at_max  ? '0      : value + ONE;
    next_down    = at_zero ? MAX_VAL : value - ONE;
  end

  always_ff @(negedge clock) begin
    if (clear) begin
      value <= '0;
    end else if (load) begin
      value <= load_clamped;
    end else if (step) begin
      value <= (up == DIR_UP) ? next_up : next_down;
    end
  end

endmodule

// File: rtl/mod_n_updown_counter.sv
// Synchronous multi-digit modulo-N up/down counter; all digits update on the same falling edge.
// Load/step visible one edge later; tc is combinational; wrapped is a registered one-cycle pulse.
module mod_n_updown_counter
  import mod_n_updown_counter_pkg::*;
#(
  parameter int DIGITS  = DEF_DIGITS,
  parameter int MODULUS = DEF_MODULUS,
  parameter int DIGIT_W = DEF_DIGIT_W,
  parameter int WRAP    = WRAP_MODE
) (
  input  logic                      clock,
  input  logic                      clear,
  input  logic                      enable,
  input  logic                      up,
  input  logic                      load,
  input  logic [DIGITS*DIGIT_W-1:0] load_value,
  output logic [DIGITS*DIGIT_W-1:0] count,
  output logic                      tc,
  output logic                      wrapped
);

  localparam bit WRAP_EN = (WRAP == WRAP_MODE);

  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_zero;
  logic [DIGITS-1:0] step;
  logic [DIGITS:0]   max_below;
  logic [DIGITS:0]   zero_below;
  logic              terminal;
  logic              advance;

  // max_below[k] / zero_below[k]: every digit below k sits at max / zero.
  assign max_below[0]  = 1'b1;
  assign zero_below[0] = 1'b1;

  assign terminal = (up == DIR_UP) ? max_below[DIGITS] : zero_below[DIGITS];
  assign advance  = enable & (WRAP_EN | ~terminal);
  assign tc       = enable & terminal;

  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      assign max_below[k+1]  = max_below[k]  & at_max[k];
      assign zero_below[k+1] = zero_below[k] & at_zero[k];
      assign step[k] = advance & ((up == DIR_UP) ? max_below[k] : zero_below[k]);

      mod_n_updown_counter_digit #(
        .MODULUS (MODULUS),
        .DIGIT_W (DIGIT_W)
      ) u_digit (
        .clock      (clock),
        .clear      (clear),
        .load       (load),
        .load_digit (load_value[k*DIGIT_W +: DIGIT_W]),
        .step       (step[k]),
        .up         (up),
        .value      (count[k*DIGIT_W +: DIGIT_W]),
        .at_max     (at_max[k]),
        .at_zero    (at_zero[k])
      );
    end
  endgenerate

  // In saturate mode advance is low at terminal, so the pulse can never fire.
  always_ff @(negedge clock) begin
    if (clear || load) begin
      wrapped <= 1'b0;
    end else begin
      wrapped <= advance & terminal;
    end
  end

endmodule
